bt_time_cmd_parser: RTL and testbench

Byte-stream command parser that sits directly upstream of the clock counter, between the Bluetooth UART receiver and the time-set inputs. It assembles an ASCII set-time frame `T` + `HHMMSS` + CR/LF, validates each digit and the time range, and presents the six decoded BCD digits with a one-cycle `load` strobe. Malformed, out-of-range or stalled frames are dropped and flagged on `frame_err`.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/bt_time_cmd_parser.sv | 130 +++++++++++++
 tb/tb_bt_time_cmd_parser.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock block's Bluetooth time-set command parser.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        TERM
    } parser_state_t;

    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;

    localparam int unsigned IDX_U_SEG   = 0;
    localparam int unsigned IDX_D_SEG   = 1;
    localparam int unsigned IDX_U_MIN   = 2;
    localparam int unsigned IDX_D_MIN   = 3;
    localparam int unsigned IDX_U_HOURS = 4;
    localparam int unsigned IDX_D_HOURS = 5;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/bt_time_cmd_parser.sv
// Parses "T" + HHMMSS + CR/LF from the UART byte stream into BCD time digits,
// with a one-cycle load strobe on a valid frame and frame_err on any rejected one.
module bt_time_cmd_parser
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic            clk,
    input  logic            srst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic [5:0][7:0] time_h_m_s,
    output logic            load,
    output logic            frame_err,
    output logic            busy
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    parser_state_t   state_q, state_d;
    logic [2:0]      k_q, k_d;
    logic [5:0][3:0] shadow_q, shadow_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0][7:0] time_q, time_d;
    logic            load_q, load_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic            range_ok;

    always_comb begin
        range_ok = (shadow_q[IDX_D_HOURS] <= 4'd2)
                && ((shadow_q[IDX_D_HOURS] < 4'd2) || (shadow_q[IDX_U_HOURS] <= 4'd3))
                && (shadow_q[IDX_D_MIN] <= 4'd5)
                && (shadow_q[IDX_D_SEG] <= 4'd5);
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        cnt_d    = '0;
        time_d   = time_q;
        load_d   = 1'b0;
        err_d    = 1'b0;

        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == ASCII_T) begin
                        state_d = DIGITS;
                        k_d     = '0;
                    end
                end
                DIGITS: begin
                    if (is_digit(rx_data)) begin
                        // ASCII digits carry their value in the low nibble
                        shadow_d[3'd5 - k_q] = rx_data[3:0];
                        if (k_q == 3'd5) begin
                            state_d = TERM;
                            k_d     = '0;
                        end else begin
                            k_d = k_q + 3'd1;
                        end
                    end else if (rx_data == ASCII_T) begin
                        err_d = 1'b1;
                        k_d   = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        k_d     = '0;
                    end
                end
                TERM: begin
                    state_d = IDLE;
                    if ((rx_data == ASCII_CR) || (rx_data == ASCII_LF)) begin
                        if (range_ok) begin
                            load_d = 1'b1;
                            for (int unsigned i = 0; i < 6; i++) begin
                                time_d[i] = {4'b0000, shadow_q[i]};
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A byte in the expiry cycle takes the branch above, so it wins over the timeout
            if (cnt_q == CNT_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
                k_d     = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            time_q   <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            time_q   <= time_d;
            load_q   <= load_d;
            err_q    <= err_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign time_h_m_s = time_q;
    assign load       = load_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bt_time_cmd_parser.sv
// Scoreboard bench for bt_time_cmd_parser: expected pulses are queued as bytes are
// driven and matched (kind, value, edge) when the DUT raises load or frame_err.
module tb_bt_time_cmd_parser;

    localparam int unsigned TO = 16;

    logic            clk = 1'b0;
    logic            srst = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic [5:0][7:0] tm;
    logic            load;
    logic            frame_err;
    logic            busy;

    typedef struct {
        logic        ld;
        logic        er;
        logic [47:0] val;
        int unsigned cyc;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned edges = 0;
    int unsigned last_edge = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [47:0] model_time = '0;

    bt_time_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .srst       (srst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .time_h_m_s (tm),
        .load       (load),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        ev_t e;
        if (load || frame_err) begin
            checks++;
            if (load && frame_err) begin
                errors++;
                $display("FAIL pulse_overlap: load=1 frame_err=1 at edge %0d, required never both", edges);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: load=%0b frame_err=%0b time=%h at edge %0d, required no pulse",
                         load, frame_err, tm, edges);
            end else begin
                e = exp_q.pop_front();
                if (load !== e.ld || frame_err !== e.er || tm !== e.val || edges !== e.cyc)
                begin
                    errors++;
                    $display("FAIL pulse_match: got load=%0b err=%0b time=%h edge=%0d, required load=%0b err=%0b time=%h edge=%0d",
                             load, frame_err, tm, edges, e.ld, e.er, e.val, e.cyc);
                end
            end
        end
    end

    task automatic send(input byte b);
        @(negedge clk);
        rx_data   = b;
        rx_valid  = 1'b1;
        last_edge = edges + 1;
    endtask

    task automatic idle(input int unsigned n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_str(input string s, input bit b2b);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (!b2b) idle(2);
        end
    endtask

    // Sends "T"+s+term and queues the expected outcome from an independent range check.
    task automatic frame(input string s, input byte term, input bit b2b);
        logic [47:0] v;
        int hh, mm, ss;
        send_str({"T", s}, b2b);
        send(term);
        v = '0;
        for (int i = 0; i < 6; i++) v = {v[39:0], 8'(s[i] - 8'h30)};
        hh = (int'(s[0]) - 48) * 10 + (int'(s[1]) - 48);
        mm = (int'(s[2]) - 48) * 10 + (int'(s[3]) - 48);
        ss = (int'(s[4]) - 48) * 10 + (int'(s[5]) - 48);
        if (hh <= 23 && mm <= 59 && ss <= 59) begin
            exp_q.push_back('{1'b1, 1'b0, v, last_edge});
            model_time = v;
        end else begin
            exp_q.push_back('{1'b0, 1'b1, model_time, last_edge});
        end
        if (!b2b) idle(2);
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        checks++; if (tm !== 48'h0) begin errors++; $display("FAIL reset_time: got %h, required 0", tm); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b, required 0", load); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_basic();
        frame("123456", 8'h0D, 1'b0);
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: %0d pulses outstanding, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_range();
        frame("235959", 8'h0A, 1'b0);
        frame("240000", 8'h0D, 1'b0);
        frame("196059", 8'h0D, 1'b0);
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL range_missing: %0d pulses outstanding, required 0", exp_q.size()); end
        exp_q.delete();
        checks++;
        if (tm !== 48'h02_03_05_09_05_09) begin errors++; $display("FAIL range_hold: got %h, required 020305090509", tm); end
    endtask

    task automatic test_bad_char();
        send_str("T12", 1'b0);
        send("a");
        exp_q.push_back('{1'b0, 1'b1, model_time, last_edge});
        idle(3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL badchar_busy: got %b, required 0", busy); end
        send_str("T1", 1'b0);
        send("T");
        exp_q.push_back('{1'b0, 1'b1, model_time, last_edge});
        idle(2);
        send_str("000000", 1'b0);
        send(8'h0A);
        exp_q.push_back('{1'b1, 1'b0, 48'h0, last_edge});
        model_time = '0;
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL badchar_missing: %0d pulses outstanding, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int unsigned e;
        send_str("T1", 1'b0);
        send("2");
        e = last_edge;
        exp_q.push_back('{1'b0, 1'b1, model_time, e + TO});
        idle(TO + 4);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b, required 0", busy); end
        // Next byte lands exactly on the expiry edge and must keep the frame alive
        send_str("T1", 1'b0);
        send("2");
        idle(TO - 1);
        send("3");
        idle(2);
        send_str("456", 1'b0);
        send(8'h0D);
        exp_q.push_back('{1'b1, 1'b0, 48'h01_02_03_04_05_06, last_edge});
        model_time = 48'h01_02_03_04_05_06;
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_missing: %0d pulses outstanding, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_srst_midframe();
        send_str("T123", 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        srst     = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        model_time = '0;
        checks++;
        if (tm !== 48'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL srst_clear: got time=%h busy=%b, required time=0 busy=0", tm, busy);
        end
        send_str("456", 1'b0);
        send(8'h0D);
        idle(4);
        checks++;
        if (tm !== 48'h0) begin errors++; $display("FAIL srst_hold: got %h, required 0", tm); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL srst_missing: %0d pulses outstanding, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        frame("075930", 8'h0D, 1'b1);
        send(8'h0A);
        idle(4);
        checks++;
        if (tm !== 48'h00_07_05_09_03_00) begin errors++; $display("FAIL b2b_value: got %h, required 000705090300", tm); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b, required 0", busy); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: %0d pulses outstanding, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_bad_char();
        test_timeout();
        test_srst_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
